// File: rtl/adc_scan_uart_tx.sv
// adc_scan_uart_tx
//   Round-robin ADC scanner with an asynchronous serial transmitter.
//   Steps an external ADC through NUM_CH analog mux channels, captures each
//   DATA_W-bit conversion and sends it MSB first as a serial frame:
//   start(0), data, optional parity, stop(1). Each bit lasts BIT_CYC clocks.
//   A frame only starts while the receiver asserts dsr.
//
// Ports
//   clock      : rising-edge clock
//   reset      : synchronous, active-low reset
//   eoc        : ADC end-of-conversion (1 = converting, 0 = result valid)
//   data_in    : ADC result
//   dsr        : receiver ready, sampled only when a frame is about to start
//   soc        : start-of-conversion to the ADC
//   load_dato  : one-cycle pulse when data_in is captured
//   mux_en     : analog mux enable
//   canale     : selected mux channel
//   data_out   : serial line, idles high
//   error      : sticky, set when a frame start is refused (dsr=0)
//   tx_busy    : high from first start-bit cycle through last stop-bit cycle
//   frame_done : one-cycle pulse in the last stop-bit cycle
module adc_scan_uart_tx #(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 8,
    parameter int CH_W       = 4,
    parameter int BIT_CYC    = 104,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              eoc,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dsr,
    output logic              soc,
    output logic              load_dato,
    output logic              mux_en,
    output logic [CH_W-1:0]   canale,
    output logic              data_out,
    output logic              error,
    output logic              tx_busy,
    output logic              frame_done
);

    localparam int CYC_W = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYC - 1);
    localparam logic [CYC_W-1:0] CYC_PRE  = CYC_W'(BIT_CYC - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic             PAR_INV  = (PARITY_ODD != 0);
    localparam logic             PAR_ON   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUX,
        S_SETTLE,
        S_SOC,
        S_WAIT,
        S_REQ,
        S_NEXT
    } scan_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_PARITY,
        T_STOP
    } tx_state_t;

    scan_state_t       scan_state_reg;
    tx_state_t         tx_state_reg;

    logic              soc_reg;
    logic              load_dato_reg;
    logic              mux_en_reg;
    logic [CH_W-1:0]   canale_reg;
    logic [DATA_W-1:0] hold_reg;

    logic              data_out_reg;
    logic              error_reg;
    logic              tx_busy_reg;
    logic              frame_done_reg;
    logic [DATA_W-1:0] tx_shift_reg;
    logic              tx_parity_reg;
    logic [CYC_W-1:0]  cyc_cnt_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;

    logic              tx_start;
    logic              tx_refused;
    logic [DATA_W:0]   par_chain;

    // The handshake is only evaluated while the transmitter is truly idle,
    // so a request during the frame_done cycle waits one more cycle.
    assign tx_start   = (scan_state_reg == S_REQ) && (tx_state_reg == T_IDLE) && dsr;
    assign tx_refused = (scan_state_reg == S_REQ) && (tx_state_reg == T_IDLE) && !dsr;

    // Parity over the held sample; seeding with PAR_INV yields odd parity.
    assign par_chain[0] = PAR_INV;
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ hold_reg[gi];
        end
    endgenerate

    // Scan sequencer: select channel, settle, convert, capture, hand off.
    always_ff @(posedge clock) begin
        if (!reset) begin
            scan_state_reg <= S_IDLE;
            soc_reg        <= 1'b0;
            load_dato_reg  <= 1'b0;
            mux_en_reg     <= 1'b0;
            canale_reg     <= '0;
            hold_reg       <= '0;
        end else begin
            load_dato_reg <= 1'b0;
            case (scan_state_reg)
                S_IDLE:   scan_state_reg <= S_MUX;
                S_MUX: begin
                    mux_en_reg     <= 1'b1;
                    scan_state_reg <= S_SETTLE;
                end
                S_SETTLE: scan_state_reg <= S_SOC;
                S_SOC: begin
                    soc_reg        <= 1'b1;
                    scan_state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (!eoc) begin
                        load_dato_reg  <= 1'b1;
                        hold_reg       <= data_in;
                        mux_en_reg     <= 1'b0;
                        soc_reg        <= 1'b0;
                        scan_state_reg <= S_REQ;
                    end
                end
                // Stay here until the frame is accepted; the sample is never
                // dropped and the channel does not advance meanwhile.
                S_REQ: begin
                    if (tx_start) begin
                        scan_state_reg <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    canale_reg     <= (canale_reg == CH_LAST) ? '0 : canale_reg + 1'b1;
                    scan_state_reg <= S_IDLE;
                end
                default:  scan_state_reg <= S_IDLE;
            endcase
        end
    end

    // Serial transmitter. The sample is copied into a private shift register
    // at frame start so the scanner may capture the next one mid-frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_state_reg   <= T_IDLE;
            data_out_reg   <= 1'b1;
            error_reg      <= 1'b0;
            tx_busy_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            tx_shift_reg   <= '0;
            tx_parity_reg  <= 1'b0;
            cyc_cnt_reg    <= '0;
            bit_cnt_reg    <= '0;
        end else begin
            frame_done_reg <= 1'b0;

            if (tx_start) begin
                error_reg <= 1'b0;
            end else if (tx_refused) begin
                error_reg <= 1'b1;
            end

            case (tx_state_reg)
                T_IDLE: begin
                    if (tx_start) begin
                        tx_state_reg  <= T_START;
                        data_out_reg  <= 1'b0;
                        tx_busy_reg   <= 1'b1;
                        tx_shift_reg  <= hold_reg;
                        tx_parity_reg <= par_chain[DATA_W];
                        cyc_cnt_reg   <= '0;
                        bit_cnt_reg   <= '0;
                    end
                end
                T_START: begin
                    if (cyc_cnt_reg == CYC_LAST) begin
                        cyc_cnt_reg  <= '0;
                        data_out_reg <= tx_shift_reg[DATA_W-1];
                        tx_shift_reg <= tx_shift_reg << 1;
                        tx_state_reg <= T_DATA;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
                    end
                end
                T_DATA: begin
                    if (cyc_cnt_reg == CYC_LAST) begin
                        cyc_cnt_reg <= '0;
                        if (bit_cnt_reg == BIT_LAST) begin
                            bit_cnt_reg <= '0;
                            if (PAR_ON) begin
                                data_out_reg <= tx_parity_reg;
                                tx_state_reg <= T_PARITY;
                            end else begin
                                data_out_reg <= 1'b1;
                                tx_state_reg <= T_STOP;
                            end
                        end else begin
                            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                            data_out_reg <= tx_shift_reg[DATA_W-1];
                            tx_shift_reg <= tx_shift_reg << 1;
                        end
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
                    end
                end
                T_PARITY: begin
                    if (cyc_cnt_reg == CYC_LAST) begin
                        cyc_cnt_reg  <= '0;
                        data_out_reg <= 1'b1;
                        tx_state_reg <= T_STOP;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
                    end
                end
                T_STOP: begin
                    if (cyc_cnt_reg == CYC_LAST) begin
                        cyc_cnt_reg  <= '0;
                        tx_busy_reg  <= 1'b0;
                        tx_state_reg <= T_IDLE;
                    end else begin
                        cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
                        // Registered pulse lands in the final stop-bit cycle.
                        if (cyc_cnt_reg == CYC_PRE) begin
                            frame_done_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_state_reg <= T_IDLE;
                    data_out_reg <= 1'b1;
                    tx_busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign soc        = soc_reg;
    assign load_dato  = load_dato_reg;
    assign mux_en     = mux_en_reg;
    assign canale     = canale_reg;
    assign data_out   = data_out_reg;
    assign error      = error_reg;
    assign tx_busy    = tx_busy_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: doc/adc_scan_uart_tx.md
Name: adc_scan_uart_tx

Overview:
Parametrised successor of the single-channel ADC-to-serial controller. It round-robins an external ADC over NUM_CH multiplexer channels and captures each DATA_W-bit conversion. Each sample is sent MSB-first as an asynchronous serial frame with optional parity, gated by the dsr handshake. It sits between the ADC/analog mux front end and the serial line driver.

Parameters:
DATA_W, 8, conversion/data bits per frame (1..16)
NUM_CH, 8, number of scanned channels (2..16); canale wraps at NUM_CH-1
CH_W, 4, width of canale; must satisfy 2**CH_W >= NUM_CH
BIT_CYC, 104, clock cycles per serial bit (>=2)
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)

Ports:
clock  in  1  single rising-edge clock
reset  in  1  synchronous, active-low reset
eoc  in  1  ADC end-of-conversion; 1 = converting, 0 = result valid
data_in  in  DATA_W  ADC result
dsr  in  1  receiver ready; must be 1 for a frame to start
soc  out  1  start-of-conversion to ADC
load_dato  out  1  one-cycle pulse: data_in captured
mux_en  out  1  analog mux enable
canale  out  CH_W  selected channel
data_out  out  1  serial line, idle 1
error  out  1  sticky flag: frame start refused because dsr=0
tx_busy  out  1  transmitter mid-frame
frame_done  out  1  one-cycle pulse in the last cycle of the stop bit

Behaviour:
- Reset (reset=0 at posedge): scan FSM=S_IDLE, tx FSM=T_IDLE. soc=0, load_dato=0, mux_en=0, canale=0, data_out=1, error=0, tx_busy=0, frame_done=0. Holding reg=0, bit counter=0, cycle counter=0.
- Reset mid-frame aborts the frame: data_out=1 on the next cycle. No frame_done.
- Scan FSM, one transition per cycle unless a wait is stated:
  - S_IDLE -> S_MUX.
  - S_MUX: mux_en=1 -> S_SETTLE.
  - S_SETTLE -> S_SOC.
  - S_SOC: soc=1 -> S_WAIT.
  - S_WAIT: stay while eoc=1. When eoc=0: load_dato=1 for this cycle only, hold<=data_in, mux_en=0, soc=0 -> S_REQ.
  - S_REQ: when tx FSM is T_IDLE, issue start and go to S_NEXT.
  - S_NEXT: canale<=(canale==NUM_CH-1)?0:canale+1 -> S_IDLE.
- Capture latency: data_in sampled on the edge where eoc=0 is seen in S_WAIT.
- canale holds during a conversion and changes only in S_NEXT.
- Start handshake in S_REQ:
  - dsr=1 at the start edge: the frame begins, error<=0.
  - dsr=0: error<=1, stay in S_REQ and retry every cycle; no sample is dropped and canale does not advance.
- Tx frame: start bit 0, then DATA_W data bits MSB first, then parity (if PARITY_EN), then stop bit 1.
  - Each bit drives data_out for exactly BIT_CYC cycles.
  - First start-bit cycle is the cycle after the start edge.
  - Frame length = BIT_CYC*(DATA_W+2+PARITY_EN) cycles.
- Parity = XOR of the data bits, inverted when PARITY_ODD=1.
- tx_busy=1 from the first start-bit cycle through the last stop-bit cycle.
- frame_done pulses in the final stop-bit cycle; the tx FSM is back in T_IDLE on the next cycle.
- Simultaneous events:
  - A start request in the cycle frame_done is asserted is not accepted (tx not yet idle). It is accepted one cycle later.
  - dsr is sampled only at frame start; dsr falling mid-frame does not affect the frame or error.
- Counters: cycle counter width is clog2(BIT_CYC) and wraps to 0 at BIT_CYC-1. No free-running overflow.

Test Plan:
- Defaults, dsr=1, eoc low 3 cycles after soc, data_in=8'hA5 -> load_dato one pulse; data_out = 0,1,0,1,0,0,1,0,1,1, each bit 104 cycles; frame_done once; canale 0->1.
- 8 consecutive conversions -> canale sequence 1..7 then 0; no sample lost.
- dsr=0 for 50 cycles at S_REQ -> error=1 within 1 cycle, data_out stays 1; dsr=1 -> frame starts next cycle and error clears.
- PARITY_EN=1, PARITY_ODD=1, BIT_CYC=4, data_in=8'h03 -> parity bit 1; total frame 44 cycles.
- eoc held 1 for 500 cycles -> remains in S_WAIT, soc=1, mux_en=1, no load_dato.
- reset=0 during data bit 3 -> next cycle data_out=1, tx_busy=0, canale=0; normal scan resumes after release.
